// File: rtl/square_root_extractor_if.sv
// Start/done handshake and result bus for square_root_extractor.
// master drives the request side; slave is the extractor itself.
interface square_root_extractor_if #(
  parameter int unsigned WIDTH = 6
) ();
  localparam int unsigned ROOT_W = WIDTH / 2;

  logic              start;
  logic [WIDTH-1:0]  radicand;
  logic              busy;
  logic              done;
  logic [ROOT_W-1:0] root;
  logic [ROOT_W:0]   remainder;
  logic              exact;

  modport master (
    output start, radicand,
    input  busy, done, root, remainder, exact
  );

  modport slave (
    input  start, radicand,
    output busy, done, root, remainder, exact
  );
endinterface

// File: rtl/square_root_extractor.sv
// Sequential restoring square root: one root bit per clock, start/done handshake.
// Optional macro SQRT_RESTART_EN: start during CALC restarts from the new radicand.
module square_root_extractor #(
  parameter int unsigned WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  square_root_extractor_if.slave sq
);
  localparam int unsigned ROOT_W = WIDTH / 2;
  localparam int unsigned REM_W  = ROOT_W + 1;
  localparam int unsigned ACC_W  = ROOT_W + 2;
  localparam int unsigned CNT_W  = $clog2(ROOT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [ROOT_W-1:0]  q_q, q_d;
  logic [ACC_W-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ROOT_W-1:0]  root_q, root_d;
  logic [REM_W-1:0]   remainder_q, remainder_d;
  logic               exact_q, exact_d;

  logic [ACC_W-1:0]   r_shift_c;
  logic [ACC_W-1:0]   trial_c;
  logic               ge_c;
  logic [ACC_W-1:0]   r_iter_c;
  logic [ROOT_W-1:0]  q_iter_c;
  logic               accept_c;

  // One restoring step: bring down two radicand bits, try subtracting (4q+1).
  always_comb begin
    r_shift_c = ACC_W'({r_q, shreg_q[WIDTH-1 -: 2]});
    trial_c   = {q_q, 2'b01};
    ge_c      = (r_shift_c >= trial_c);
    r_iter_c  = ge_c ? (r_shift_c - trial_c) : r_shift_c;
    q_iter_c  = ROOT_W'({q_q, ge_c});
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    root_d      = root_q;
    remainder_d = remainder_q;
    exact_d     = exact_q;
    accept_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        accept_c = sq.start;
      end
      S_CALC: begin
`ifdef SQRT_RESTART_EN
        accept_c = sq.start;
`endif
        if (!accept_c) begin
          shreg_d = WIDTH'({shreg_q, 2'b00});
          r_d     = r_iter_c;
          q_d     = q_iter_c;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            root_d      = q_iter_c;
            remainder_d = REM_W'(r_iter_c);
            exact_d     = (r_iter_c == '0);
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Fresh load; published results stay untouched until the next completion.
    if (accept_c) begin
      shreg_d = sq.radicand;
      q_d     = '0;
      r_d     = '0;
      cnt_d   = CNT_W'(ROOT_W);
      busy_d  = 1'b1;
      state_d = S_CALC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      root_q      <= '0;
      remainder_q <= '0;
      exact_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      root_q      <= root_d;
      remainder_q <= remainder_d;
      exact_q     <= exact_d;
    end
  end

  assign sq.busy      = busy_q;
  assign sq.done      = done_q;
  assign sq.root      = root_q;
  assign sq.remainder = remainder_q;
  assign sq.exact     = exact_q;

endmodule

// File: tb/tb_square_root_extractor.sv
// Scoreboard bench for square_root_extractor (WIDTH=6); honours SQRT_RESTART_EN.
module tb_square_root_extractor;
  localparam int unsigned W = 6;

  typedef struct {
    int unsigned rad;
    int unsigned root;
    int unsigned rem;
    int unsigned exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t sb[$];
  int done_at[$];

  square_root_extractor_if #(.WIDTH(W)) sq_if ();

  square_root_extractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int unsigned x);
    exp_t e;
    e.rad  = x;
    e.root = 0;
    for (int i = 0; i * i <= x; i++) e.root = i;
    e.rem   = x - e.root * e.root;
    e.exact = (e.rem == 0) ? 1 : 0;
    return e;
  endfunction

  // Result checker: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && sq_if.done) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_eq("root", sq_if.root, e.root);
        check_eq("remainder", sq_if.remainder, e.rem);
        check_eq("exact", sq_if.exact, e.exact);
        check_eq("invariant", sq_if.root * sq_if.root + sq_if.remainder, e.rad);
        check_eq("rem_le_2root", (sq_if.remainder <= 2 * sq_if.root) ? 1 : 0, 1);
      end
    end
  end

  task automatic do_op(input int unsigned rad);
    int   n;
    bit   seen;
    exp_t ex;
    ex = model(rad);
    @(negedge clk);
    sq_if.start    = 1'b1;
    sq_if.radicand = W'(rad);
    sb.push_back(ex);
    @(posedge clk); #1;
    sq_if.start    = 1'b0;
    sq_if.radicand = W'($urandom);
    check_eq("busy_accept", sq_if.busy, 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (sq_if.done) seen = 1'b1;
      else check_eq("busy_calc", sq_if.busy, 1);
    end
    check_eq("latency", n, 3);
    check_eq("busy_at_done", sq_if.busy, 0);
    @(posedge clk); #1;
    check_eq("done_width", sq_if.done, 0);
    check_eq("hold_root", sq_if.root, ex.root);
    check_eq("hold_rem", sq_if.remainder, ex.rem);
  endtask

  initial begin
    int n;
    int exp_lat;
    int unsigned sq_vals[8];
    sq_if.start    = 1'b0;
    sq_if.radicand = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_busy", sq_if.busy, 0);
    check_eq("rst_done", sq_if.done, 0);
    check_eq("rst_root", sq_if.root, 0);
    check_eq("rst_rem", sq_if.remainder, 0);
    check_eq("rst_exact", sq_if.exact, 0);

    do_op(49);
    do_op(63);
    do_op(0);
    do_op(2);

    for (int i = 0; i < 64; i++) do_op(i);

    for (int i = 0; i < 8; i++) sq_vals[i] = i * i;
    for (int i = 0; i < 8; i++) do_op(sq_vals[i]);

    // Second start one cycle after acceptance.
    @(negedge clk);
    sq_if.start    = 1'b1;
    sq_if.radicand = W'(36);
`ifdef SQRT_RESTART_EN
    sb.push_back(model(10));
    exp_lat = 4;
`else
    sb.push_back(model(36));
    exp_lat = 3;
`endif
    @(posedge clk); #1;
    sq_if.radicand = W'(10);
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    n = 1;
    while (!sq_if.done && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("restart_latency", n, exp_lat);
    repeat (6) begin
      @(posedge clk); #1;
      check_eq("restart_single_done", sq_if.done, 0);
    end

    // Reset during the second CALC cycle.
    do_op(63);
    @(negedge clk);
    sq_if.start    = 1'b1;
    sq_if.radicand = W'(36);
    @(posedge clk); #1;
    sq_if.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", sq_if.busy, 0);
    check_eq("abort_done", sq_if.done, 0);
    check_eq("abort_root", sq_if.root, 0);
    check_eq("abort_rem", sq_if.remainder, 0);
    check_eq("abort_exact", sq_if.exact, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check_eq("abort_no_done", sq_if.done, 0);
    end
    do_op(25);

    // start held high: one acceptance every five edges.
    @(negedge clk);
    sq_if.start    = 1'b1;
    sq_if.radicand = W'(16);
    repeat (3) sb.push_back(model(16));
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 11) sq_if.start = 1'b0;
      if (sq_if.done) done_at.push_back(c);
    end
    check_eq("b2b_count", done_at.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < done_at.size()) check_eq("b2b_edge", done_at[i], 3 + 5 * i);

    repeat (3) @(posedge clk);
    #1 check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/square_root_extractor.md
Name: square_root_extractor

Overview:
- Sequential integer square-root unit; the inverse of the team's combinational square generator.
- Accepts a WIDTH-bit radicand on a start pulse.
- Uses the digit-by-digit (restoring) method, resolving one root bit per clock.
- Returns floor root, remainder and an exact-square flag with a done pulse.
- Used in the lab datapath to round-trip square-generator outputs and as a multicycle start/done handshake example.

Parameters:
- WIDTH, 6, radicand width in bits; must be even and >= 2; root width is WIDTH/2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- radicand  input  WIDTH  value to root; captured on the accepted start edge.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse, result valid.
- root  output  WIDTH/2  floor(sqrt(radicand)).
- remainder  output  WIDTH/2+1  radicand - root*root.
- exact  output  1  high when remainder == 0.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, root=0, remainder=0, exact=0, iteration counter=0.
- Reset mid-operation: abort immediately, with no done pulse; all outputs return to the reset values on that edge.
- States:
  - IDLE: start=1 -> capture radicand into a shift register; clear partial root q and partial remainder r; load counter=WIDTH/2; busy=1; -> CALC. start=0 -> stay.
  - CALC: one iteration per edge:
    - r' = (r<<2) | top two bits of the shift register; shift register <<= 2.
    - t = (q<<2) | 1.
    - If r' >= t (unsigned): r = r' - t, q = (q<<1)|1.
    - Else: r = r', q = q<<1.
    - Counter decrements each iteration.
    - On the final iteration (counter==1): write the final q to root and the final r to remainder; exact = (final r == 0); done=1; busy=0; -> DONE.
  - DONE: done drops to 0 on the next edge; -> IDLE unconditionally. start during DONE is ignored.
- Datapath widths:
  - r and the comparison are WIDTH/2+2 bits wide; no overflow is possible.
  - Maximum remainder is 2*root, which fits in WIDTH/2+1 bits.
- Latency:
  - done rises exactly WIDTH/2 edges after the edge that accepts start (3 for WIDTH=6).
  - Throughput is one result per WIDTH/2+2 cycles.
- Hold: root, remainder and exact are registered and held stable from the done edge until the edge that completes the next computation. They do not change during CALC.
- start while busy (CALC) or in DONE: ignored, with no side effects. This default is overridden by the option below.
- radicand changes after acceptance have no effect.
- Radicand 0: root=0, remainder=0, exact=1, same latency.

Optional Feature:
- Macro: SQRT_RESTART_EN.
- Defined: start=1 in CALC aborts the current computation and reloads from the new radicand on that edge. Counter resets to WIDTH/2, busy stays 1, and no done pulse is produced for the aborted request. done then follows WIDTH/2 edges after the restarting edge. root/remainder/exact keep the previous completed result until then.
- Undefined: start in CALC is ignored, as specified above.

Test Plan:
- Reset, then start with radicand=49 -> done pulse exactly 3 edges later (WIDTH=6), one cycle wide; root=7, remainder=0, exact=1; busy high for those 3 cycles.
- radicand=63 -> root=7, remainder=14, exact=0. radicand=0 -> root=0, remainder=0, exact=1. radicand=2 -> root=1, remainder=1, exact=0.
- Exhaustive 0..63: check root*root + remainder == radicand and remainder <= 2*root. Feed the 3-bit square-generator outputs {0,1,4,9,16,25,36,49} back in -> roots 0..7, all exact=1.
- Assert start again one cycle after acceptance with radicand=10, first radicand=36:
  - Macro undefined -> single done with root=6, remainder=0.
  - SQRT_RESTART_EN defined -> single done 3 edges after the restart edge with root=3, remainder=1.
- Assert rst for one cycle during the second CALC cycle -> no done, all outputs 0. Then start with radicand=25 -> root=5, exact=1 with normal latency.
- start held high continuously with radicand=16 -> back-to-back results every 5 cycles (WIDTH/2+2), each root=4. start during the DONE cycle is not accepted.
